buffer_slots_fifo: RTL
======================

Name: buffer_slots_fifo

Overview:
Parametrised successor to the single-overflow-slot pipeline buffer. It has one registered output ("main") slot backed by a DEPTH-entry overflow FIFO, so several back-to-back words can be absorbed while downstream stalls. Input uses a valid/ready handshake. Order is preserved strictly. It raises an almost-full flag to stall management and keeps a sticky error if a word is lost. It sits between a producer stage and a stallable consumer stage.

Parameters:
WIDTH, 32, data word width in bits (>=1).
DEPTH, 4, overflow FIFO entries; power of two, >=2.
AFULL_LVL, DEPTH-1, occupancy at or above which to_stall_mgmt asserts (1..DEPTH).

Ports:
clk  in  1  clock; all logic on posedge.
reset  in  1  synchronous, active-high reset.
in_valid  in  1  producer offers in_data this cycle.
in_data  in  WIDTH  producer word.
in_ready  out  1  block accepts a word this cycle; equals (occupancy != DEPTH), from state only.
stall  in  1  downstream stall; main slot must hold.
out_valid  out  1  out_data holds a valid word (registered).
out_data  out  WIDTH  main slot contents (registered).
occupancy  out  $clog2(DEPTH+1)  overflow FIFO entry count; excludes the main slot.
to_stall_mgmt  out  1  occupancy >= AFULL_LVL (combinational from count).
overflow_err  out  1  sticky; a word was dropped at full.

Behaviour:
- Reset, synchronous, takes priority over everything else: out_valid=0, out_data=0, occupancy=0, pointers=0, overflow_err=0, all FIFO entries=0. Reset asserted mid-burst discards all contents.
- Accept = in_valid & in_ready.
- stall=1:
  - main slot holds out_valid and out_data.
  - An accepted word is pushed to the FIFO tail.
- stall=0, FIFO non-empty:
  - Main slot loads the FIFO head; out_valid=1; head pops.
  - An accepted word is pushed in the same cycle; occupancy is unchanged.
- stall=0, FIFO empty:
  - An accepted word bypasses into the main slot with out_valid=1 (latency 1 cycle).
  - With no accept, out_valid=0.
- A word is consumed by downstream whenever out_valid=1 and stall=0 at a clock edge.
- Full (occupancy==DEPTH): in_ready=0 even if a pop happens the same cycle. If in_valid=1 at full, the word is dropped and overflow_err sets, staying set until reset.
- Pointers wrap modulo DEPTH. Occupancy arithmetic is width-safe (count reaches DEPTH exactly).
- Ordering: a bypassing word can never overtake FIFO contents; bypass only happens when the FIFO is empty.

Optional Feature:
Macro BUFFER_SLOTS_SECURE_CLEAR_EN.
- Defined: a popped FIFO entry is written to 0 on the pop cycle. out_data is forced to 0 whenever out_valid deasserts.
- Undefined: popped entries and out_data retain stale values; only the pointers and count move. Valid-qualified behaviour is identical in both builds.

Decomposition:
- Package buffer_slots_pkg holds:
  - default WIDTH, DEPTH and AFULL_LVL constants.
  - a function computing count width ($clog2(DEPTH+1)).
  - a typedef for the pointer index.
- One natural sub-module, buffer_fifo_store: the DEPTH x WIDTH register array with head/tail pointers, count, push/pop and the secure-clear write.
- The top level holds the main slot, the bypass mux, and the handshake and flag logic.

Test Plan:
- No stall; drive 0xA1, 0xA2, 0xA3 on consecutive cycles -> out_data 0xA1, 0xA2, 0xA3 one cycle later each; occupancy stays 0.
- Hold stall=1 for 4 cycles with words 0x10..0x13 (DEPTH=4) -> occupancy 1,2,3,4; to_stall_mgmt rises at 3; in_ready=0 at 4. Release stall -> outputs 0x10..0x13 in order.
- At full with stall=1, drive in_valid with 0xDEAD -> word dropped, overflow_err=1. It stays 1 through drain until reset.
- FIFO holds 2 entries, stall=0, new word 0x55 arrives -> head pops while 0x55 pushes; occupancy stays 2; 0x55 exits last.
- Assert reset while occupancy=3 -> next cycle out_valid=0, occupancy=0, in_ready=1, overflow_err=0; a following word passes with 1-cycle latency.
- SECURE_CLEAR build: after draining, read the internal entries and check out_data with out_valid=0 -> all zero. The non-SECURE build retains the values.

Source files
------------

// File: rtl/buffer_slots_pkg.sv
// Shared defaults and helpers for the buffer_slots_fifo block.
// BUFFER_SLOTS_SECURE_CLEAR_EN selects zeroing of popped entries and idle out_data.
package buffer_slots_pkg;

  localparam int unsigned DefWidth    = 32;
  localparam int unsigned DefDepth    = 4;
  localparam int unsigned DefAfullLvl = DefDepth - 1;

  // Count must hold DEPTH itself, hence DEPTH+1 states.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  typedef logic [$clog2(DefDepth)-1:0] ptr_t;

endpackage

// File: rtl/buffer_fifo_store.sv
// DEPTH x WIDTH overflow store with head/tail pointers and an occupancy count.
// With BUFFER_SLOTS_SECURE_CLEAR_EN the popped entry is zeroed on the pop cycle.
module buffer_fifo_store
  import buffer_slots_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth,
  localparam int unsigned CntW = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] head_data,
  output logic [CntW-1:0]  count
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  head_q, tail_q;
  logic [CntW-1:0]  count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[tail_q] <= wr_data;
        tail_q        <= tail_q + 1'b1;
      end
      if (pop) begin
`ifdef BUFFER_SLOTS_SECURE_CLEAR_EN
        mem_q[head_q] <= '0;
`endif
        head_q <= head_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_data = mem_q[head_q];
  assign count     = count_q;

endmodule

// File: rtl/buffer_slots_fifo.sv
// Registered main output slot backed by an overflow FIFO, with almost-full and sticky drop flags.
// BUFFER_SLOTS_SECURE_CLEAR_EN forces out_data to zero whenever out_valid drops.
module buffer_slots_fifo
  import buffer_slots_pkg::*;
#(
  parameter int unsigned WIDTH     = DefWidth,
  parameter int unsigned DEPTH     = DefDepth,
  parameter int unsigned AFULL_LVL = DEPTH - 1,
  localparam int unsigned CntW     = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             stall,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CntW-1:0]  occupancy,
  output logic             to_stall_mgmt,
  output logic             overflow_err
);

  logic [CntW-1:0]  count;
  logic [WIDTH-1:0] head_data;
  logic             full, fifo_empty, accept, push, pop;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             overflow_err_q;

  assign full       = (count == CntW'(DEPTH));
  assign fifo_empty = (count == '0);
  assign in_ready   = ~full;
  assign accept     = in_valid & in_ready;
  assign pop        = ~stall & ~fifo_empty;
  // Bypass only when the FIFO is empty and the slot is free to move, so order is kept.
  assign push       = accept & (stall | ~fifo_empty);

  buffer_fifo_store #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_store (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .wr_data   (in_data),
    .head_data (head_data),
    .count     (count)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (!stall) begin
      if (!fifo_empty) begin
        out_valid_d = 1'b1;
        out_data_d  = head_data;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data;
      end else begin
        out_valid_d = 1'b0;
`ifdef BUFFER_SLOTS_SECURE_CLEAR_EN
        out_data_d  = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      overflow_err_q <= 1'b0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      overflow_err_q <= overflow_err_q | (in_valid & full);
    end
  end

  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign occupancy     = count;
  assign to_stall_mgmt = (count >= CntW'(AFULL_LVL));
  assign overflow_err  = overflow_err_q;

endmodule
